// File: rtl/gcd_stub_param.sv
// Constant/variable-latency arithmetic stub with a gcd-style result interface.
// Ports: clk, rst_n, clk_en, start, abort, constant_time, latency, op_code, A, B -> busy, done, err, cycle_count, bezout_a/b.
module gcd_stub_param #(
  parameter int WIDTH   = 1279,
  parameter int EXT     = 5,
  parameter int CNT_W   = 12,
  parameter int LAT_MAX = (2 ** CNT_W) - 1,
  parameter int RW      = WIDTH + EXT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic             abort,
  input  logic             constant_time,
  input  logic [CNT_W-1:0] latency,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycle_count,
  output logic [RW-1:0]    bezout_a,
  output logic [RW-1:0]    bezout_b
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tgt;
  logic [CNT_W-1:0] tgt_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             accept;
  logic             legal;
  logic             last;
  logic [WIDTH:0]   sum;
  logic [RW-1:0]    res_a;
  logic [RW-1:0]    res_b;

  // Abort wins over start on the same edge, and RUN ignores start.
  assign accept = start && !abort && (state != S_RUN);
  assign legal  = !op_code[2];
  assign last   = (cnt == tgt - CNT_W'(1));
  assign tgt_nx = constant_time    ? CNT_W'(LAT_MAX) :
                  (latency == '0)  ? CNT_W'(1)       : latency;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (clk_en) begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN: begin
        if (abort)     state_nx = S_IDLE;
        else if (last) state_nx = S_DONE;
      end
      default: begin
        if (accept) state_nx = legal ? S_RUN : S_DONE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == S_RUN);
  end

  // Result datapath from latched operands
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    res_a = '0;
    res_b = '0;
    case (op_q)
      3'd0: begin
        res_a[WIDTH:0]   = sum;
        res_b[WIDTH-1:0] = a_q - b_q;
      end
      3'd1: begin
        res_a[WIDTH-1:0] = a_q;
        res_b[WIDTH-1:0] = b_q;
      end
      3'd2: begin
        res_a[WIDTH-1:0] = a_q & b_q;
        res_b[WIDTH-1:0] = a_q | b_q;
      end
      3'd3: begin
        res_a[WIDTH-1:0] = a_q ^ b_q;
      end
      default: begin
        res_a = '0;
        res_b = '0;
      end
    endcase
  end

  // Counter, operand latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      tgt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      cycle_count <= '0;
      bezout_a    <= '0;
      bezout_b    <= '0;
    end else if (clk_en) begin
      if (state == S_RUN) begin
        if (abort) begin
          cnt         <= '0;
          done        <= 1'b0;
          err         <= 1'b0;
          cycle_count <= '0;
          bezout_a    <= '0;
          bezout_b    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            done        <= 1'b1;
            cycle_count <= tgt;
            bezout_a    <= res_a;
            bezout_b    <= res_b;
          end
        end
      end else if (accept) begin
        cnt         <= '0;
        tgt         <= tgt_nx;
        a_q         <= A;
        b_q         <= B;
        op_q        <= op_code;
        // Illegal codes complete on this very edge with an error flag.
        done        <= !legal;
        err         <= !legal;
        cycle_count <= legal ? CNT_W'(0) : CNT_W'(1);
        bezout_a    <= '0;
        bezout_b    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gcd_stub_param.sv
// Directed self-checking bench for gcd_stub_param.
// Small configuration: WIDTH=8, EXT=5, CNT_W=4, LAT_MAX=15.
module tb_gcd_stub_param;

  localparam int WIDTH = 8;
  localparam int EXT   = 5;
  localparam int CNT_W = 4;
  localparam int LATM  = 15;
  localparam int RW    = WIDTH + EXT;

  logic             clk;
  logic             rst_n;
  logic             clk_en;
  logic             start;
  logic             abort;
  logic             constant_time;
  logic [CNT_W-1:0] latency;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] cycle_count;
  logic [RW-1:0]    bezout_a;
  logic [RW-1:0]    bezout_b;

  int errs;
  int nchk;
  int n;

  gcd_stub_param #(
    .WIDTH(WIDTH),
    .EXT(EXT),
    .CNT_W(CNT_W),
    .LAT_MAX(LATM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .start(start),
    .abort(abort),
    .constant_time(constant_time),
    .latency(latency),
    .op_code(op_code),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .err(err),
    .cycle_count(cycle_count),
    .bezout_a(bezout_a),
    .bezout_b(bezout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [2:0] op, input logic [7:0] a,
                    input logic [7:0] b, input logic [3:0] lat,
                    input logic ct);
    op_code       = op;
    A             = a;
    B             = b;
    latency       = lat;
    constant_time = ct;
    start         = 1'b1;
    step();
    start         = 1'b0;
    // Scramble inputs to prove they were latched.
    A             = ~a;
    B             = ~b;
    op_code       = 3'd7;
    latency       = 4'd1;
    constant_time = ~ct;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    errs          = 0;
    nchk          = 0;
    rst_n         = 1'b0;
    clk_en        = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    constant_time = 1'b0;
    latency       = '0;
    op_code       = '0;
    A             = '0;
    B             = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_ba", bezout_a, 0);
    chk("rst_bb", bezout_b, 0);
    rst_n = 1'b1;

    // V1: op 0, latency 3
    go(3'd0, 8'hF0, 8'h20, 4'd3, 1'b0);
    chk("v1_busy", busy, 1);
    chk("v1_done0", done, 0);
    wait_done(n);
    chk("v1_lat", n, 3);
    chk("v1_ba", bezout_a, 13'h110);
    chk("v1_bb", bezout_b, 13'h0D0);
    chk("v1_cc", cycle_count, 3);
    chk("v1_busy_done", busy, 0);
    step();
    step();
    chk("v1_hold_done", done, 1);
    chk("v1_hold_ba", bezout_a, 13'h110);

    // V2: constant time overrides latency
    go(3'd1, 8'h12, 8'h34, 4'd2, 1'b1);
    chk("v2_clr_done", done, 0);
    chk("v2_clr_ba", bezout_a, 0);
    wait_done(n);
    chk("v2_lat", n, 15);
    chk("v2_ba", bezout_a, 13'h012);
    chk("v2_bb", bezout_b, 13'h034);
    chk("v2_cc", cycle_count, 15);

    // V3: wrap on subtract, clk_en stall
    go(3'd0, 8'h01, 8'h02, 4'd3, 1'b0);
    step();
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("v3_stall_busy", busy, 1);
    chk("v3_stall_done", done, 0);
    clk_en = 1'b1;
    wait_done(n);
    chk("v3_lat", n + 5, 7);
    chk("v3_ba", bezout_a, 13'h003);
    chk("v3_bb", bezout_b, 13'h0FF);
    chk("v3_cc", cycle_count, 3);

    // Logic ops, latency 0 acts as 1
    go(3'd2, 8'hCC, 8'hAA, 4'd0, 1'b0);
    wait_done(n);
    chk("and_lat", n, 1);
    chk("and_ba", bezout_a, 13'h088);
    chk("or_bb", bezout_b, 13'h0EE);
    go(3'd3, 8'hCC, 8'hAA, 4'd2, 1'b0);
    wait_done(n);
    chk("xor_ba", bezout_a, 13'h066);
    chk("xor_bb", bezout_b, 0);

    // V4: illegal op
    go(3'd5, 8'h11, 8'h22, 4'd6, 1'b0);
    chk("v4_done", done, 1);
    chk("v4_err", err, 1);
    chk("v4_cc", cycle_count, 1);
    chk("v4_ba", bezout_a, 0);
    chk("v4_bb", bezout_b, 0);
    chk("v4_busy", busy, 0);

    // V5: abort on 2nd RUN edge, then start+abort
    go(3'd1, 8'h55, 8'h66, 4'd8, 1'b0);
    chk("v5_err_clr", err, 0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("v5_ab_busy", busy, 0);
    chk("v5_ab_done", done, 0);
    chk("v5_ab_ba", bezout_a, 0);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("v5_sa_busy", busy, 0);
    step();
    step();
    chk("v5_sa_done", done, 0);

    // V6: async reset mid-run
    go(3'd0, 8'h03, 8'h01, 4'd5, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("v6_rst_busy", busy, 0);
    chk("v6_rst_done", done, 0);
    chk("v6_rst_cc", cycle_count, 0);
    #1 rst_n = 1'b1;
    go(3'd1, 8'h77, 8'h11, 4'd4, 1'b0);
    chk("v6_first_busy", busy, 1);
    step();
    op_code = 3'd0;
    A       = 8'h00;
    B       = 8'h00;
    latency = 4'd1;
    start   = 1'b1;
    step();
    start   = 1'b0;
    wait_done(n);
    chk("v6_lat", n + 2, 4);
    chk("v6_ba", bezout_a, 13'h077);
    chk("v6_bb", bezout_b, 13'h011);
    chk("v6_cc", cycle_count, 4);
    chk("v6_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/gcd_stub_param.md
GCD_STUB_PARAM -- requirements
Module: gcd_stub_param

Interface
- REQ-001 SHALL have parameter WIDTH, default 1279, operand width in bits.
- REQ-002 SHALL have parameter EXT, default 5, result extension bits; result width RW = WIDTH+EXT.
- REQ-003 SHALL have parameter CNT_W, default 12, cycle counter width.
- REQ-004 SHALL have parameter LAT_MAX, default 2^CNT_W-1, constant-time latency in enabled cycles; legal range 1..2^CNT_W-1.
- REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
- REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-007 SHALL have port clk_en, input, 1; when 0, all registers hold their value.
- REQ-008 SHALL have port start, input, 1, operation request.
- REQ-009 SHALL have port abort, input, 1, cancels an in-flight operation.
- REQ-010 SHALL have port constant_time, input, 1; selects latency LAT_MAX.
- REQ-011 SHALL have port latency, input, CNT_W, variable-mode latency.
- REQ-012 SHALL have port op_code, input, 3, operation select.
- REQ-013 SHALL have ports A and B, input, WIDTH each, operands.
- REQ-014 SHALL have port busy, output, 1, high while in RUN.
- REQ-015 SHALL have port done, output, 1, result valid.
- REQ-016 SHALL have port err, output, 1, illegal op_code flagged with done.
- REQ-017 SHALL have port cycle_count, output, CNT_W, enabled cycles consumed by the last operation.
- REQ-018 SHALL have ports bezout_a and bezout_b, output, RW each, results.

Function
- REQ-019 SHALL implement states IDLE, RUN, DONE; all transitions occur only on edges with clk_en=1.
- REQ-020 SHALL accept start only in IDLE or DONE; start in RUN is ignored.
- REQ-021 On accepted start SHALL latch A, B, op_code and target T = constant_time ? LAT_MAX : max(latency,1); later changes to A, B, op_code, latency and constant_time SHALL NOT affect the operation.
- REQ-022 On accepted start SHALL clear done, err, cycle_count, bezout_a and bezout_b to 0, zero the counter, and enter RUN (legal op_code) or DONE (illegal op_code).
- REQ-023 In RUN the counter SHALL increment once per enabled edge; on the enabled edge where counter == T-1 SHALL enter DONE with done=1, cycle_count=T and results registered.
- REQ-024 With clk_en held at 1, done SHALL rise exactly T edges after the edge that sampled start.
- REQ-025 op_code 0 SHALL produce bezout_a = A+B zero-extended to RW (carry kept in bit WIDTH) and bezout_b = (A-B) mod 2^WIDTH zero-extended.
- REQ-026 op_code 1 SHALL produce bezout_a = A and bezout_b = B, zero-extended.
- REQ-027 op_code 2 SHALL produce bezout_a = A&B and bezout_b = A|B; op_code 3 SHALL produce bezout_a = A^B and bezout_b = 0.
- REQ-028 op_code 4..7 SHALL be illegal: enter DONE on the next enabled edge with done=1, err=1, cycle_count=1 and results 0.
- REQ-029 In DONE the outputs done, err, cycle_count and results SHALL hold until the next accepted start.
- REQ-030 abort=1 in RUN SHALL return the FSM to IDLE on that enabled edge with done=0 and results 0; abort in IDLE or DONE has no effect.
- REQ-031 abort and start asserted together SHALL give abort priority; start is not accepted on that edge.
- REQ-032 busy SHALL equal (state==RUN); busy and done SHALL never be high together.

Reset
- REQ-033 On rst_n=0 SHALL immediately enter IDLE and set busy, done, err, cycle_count, bezout_a, bezout_b and the counter to 0, including mid-operation and regardless of clk_en.
- REQ-034 After rst_n deasserts SHALL accept start on the first enabled edge.

Verification (WIDTH=8, EXT=5, CNT_W=4, LAT_MAX=15)
- V1: start, op 0, A=0xF0, B=0x20, latency=3, constant_time=0, clk_en=1 -> done after 3 edges, bezout_a=0x110, bezout_b=0x0D0, cycle_count=3.
- V2: constant_time=1, latency=2, op 1, A=0x12, B=0x34 -> busy for 15 edges, then done, bezout_a=0x12, bezout_b=0x34, cycle_count=15.
- V3: op 0, A=0x01, B=0x02 -> bezout_b=0x0FF (wrap); clk_en low for 4 cycles mid-RUN with latency=3 -> done delayed by 4 cycles, cycle_count=3.
- V4: op 5 -> done=1, err=1, cycle_count=1, results 0 one edge after start.
- V5: abort on the 2nd RUN edge with latency=8 -> IDLE, done=0; start+abort in same cycle -> start ignored.
- V6: rst_n low while in RUN -> all outputs 0 immediately; start in RUN without abort -> ignored, original result delivered.
